// File: rtl/weight_store_if.sv
// Handshake bundle between the weight store and its reader/writer:
// layer-select requests, the read-back matrix and the write-back matrix.
interface weight_store_if #(
  parameter int NEURON_NUM        = 5,
  parameter int WEIGHT_CELL_WIDTH = 16,
  parameter int LAYER_ADDR_WIDTH  = 2
);
  localparam int MAT_W = NEURON_NUM * NEURON_NUM * WEIGHT_CELL_WIDTH;

  logic [LAYER_ADDR_WIDTH-1:0] rd_layer;
  logic                        rd_layer_valid;
  logic                        rd_layer_ready;
  logic [MAT_W-1:0]            w;
  logic                        w_valid;
  logic                        w_ready;
  logic [LAYER_ADDR_WIDTH-1:0] wr_layer;
  logic                        wr_layer_valid;
  logic                        wr_layer_ready;
  logic [MAT_W-1:0]            wr_data;
  logic                        wr_data_valid;
  logic                        wr_data_ready;
  logic                        error;

  modport master (
    output rd_layer, rd_layer_valid, w_ready, wr_layer, wr_layer_valid,
           wr_data, wr_data_valid,
    input  rd_layer_ready, w, w_valid, wr_layer_ready, wr_data_ready, error
  );

  modport slave (
    input  rd_layer, rd_layer_valid, w_ready, wr_layer, wr_layer_valid,
           wr_data, wr_data_valid,
    output rd_layer_ready, w, w_valid, wr_layer_ready, wr_data_ready, error
  );
endinterface

// File: rtl/weight_store.sv
// Register-based store of LAYER_NUM weight matrices with a one-request-at-a-time
// read/write handshake; writes win over reads when both are offered in IDLE.
//
// state   | meaning
// IDLE    | accepting a write-layer or read-layer request
// RD_HOLD | w holds the selected matrix until the consumer takes it
// WR_WAIT | layer latched, waiting for the matrix to write
module weight_store #(
  parameter int NEURON_NUM        = 5,
  parameter int WEIGHT_CELL_WIDTH = 16,
  parameter int LAYER_NUM         = 3,
  parameter int LAYER_ADDR_WIDTH  = 2
) (
  input  logic           clk,
  input  logic           rst,
  weight_store_if.slave  bus
);
  localparam int MAT_W = NEURON_NUM * NEURON_NUM * WEIGHT_CELL_WIDTH;

  typedef enum logic [1:0] {IDLE, RD_HOLD, WR_WAIT} state_t;

  state_t                      state, state_nxt;
  logic [MAT_W-1:0]            mem [LAYER_NUM];
  logic [MAT_W-1:0]            w_q;
  logic [MAT_W-1:0]            rd_sel;
  logic [LAYER_ADDR_WIDTH-1:0] wr_layer_q;
  logic                        error_q;
  logic                        rd_acc, wr_acc, wd_acc;
  logic                        rd_oor, wr_oor;

  always_comb begin
    bus.rd_layer_ready = 1'b0;
    bus.wr_layer_ready = 1'b0;
    bus.wr_data_ready  = 1'b0;
    state_nxt          = state;
    case (state)
      IDLE: begin
        bus.wr_layer_ready = 1'b1;
        bus.rd_layer_ready = !bus.wr_layer_valid;
        if (bus.wr_layer_valid)      state_nxt = WR_WAIT;
        else if (bus.rd_layer_valid) state_nxt = RD_HOLD;
      end
      RD_HOLD: if (bus.w_ready) state_nxt = IDLE;
      WR_WAIT: begin
        bus.wr_data_ready = 1'b1;
        if (bus.wr_data_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rd_acc      = bus.rd_layer_valid && bus.rd_layer_ready;
  assign wr_acc      = bus.wr_layer_valid && bus.wr_layer_ready;
  assign wd_acc      = bus.wr_data_valid && bus.wr_data_ready;
  assign rd_oor      = int'(bus.rd_layer) >= LAYER_NUM;
  assign wr_oor      = int'(bus.wr_layer) >= LAYER_NUM;
  assign bus.w       = w_q;
  assign bus.w_valid = (state == RD_HOLD);
  assign bus.error   = error_q;

  // Out-of-range layers select nothing, so the read returns zeros.
  always_comb begin
    rd_sel = '0;
    for (int l = 0; l < LAYER_NUM; l++)
      if (bus.rd_layer == LAYER_ADDR_WIDTH'(l)) rd_sel = mem[l];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      w_q        <= '0;
      error_q    <= 1'b0;
      wr_layer_q <= '0;
      for (int l = 0; l < LAYER_NUM; l++) mem[l] <= '0;
    end else begin
      state   <= state_nxt;
      error_q <= (rd_acc && rd_oor) || (wr_acc && wr_oor);
      if (rd_acc) w_q <= rd_sel;
      if (wr_acc) wr_layer_q <= bus.wr_layer;
      if (wd_acc)
        for (int l = 0; l < LAYER_NUM; l++)
          if (wr_layer_q == LAYER_ADDR_WIDTH'(l)) mem[l] <= bus.wr_data;
    end
  end
endmodule

// File: tb/tb_weight_store.sv
// Directed bench for weight_store: reset, read-after-write, priority,
// backpressure, out-of-range handling and reset during a transfer.
module tb_weight_store;
  localparam int NN  = 5;
  localparam int CW  = 16;
  localparam int LN  = 3;
  localparam int LAW = 2;
  localparam int MW  = NN * NN * CW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  weight_store_if #(.NEURON_NUM(NN), .WEIGHT_CELL_WIDTH(CW), .LAYER_ADDR_WIDTH(LAW)) bus ();

  weight_store #(
    .NEURON_NUM(NN), .WEIGHT_CELL_WIDTH(CW), .LAYER_NUM(LN), .LAYER_ADDR_WIDTH(LAW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [MW-1:0] exp_mem [LN];
  logic [MW-1:0] zero_mat;
  logic [MW-1:0] pat_a, pat_b, pat_max, pat_c;

  task automatic chk(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // cell x = base + x*step, 16-bit wrap
  function automatic logic [MW-1:0] pat(input int base, input int step);
    logic [MW-1:0] m;
    logic [CW-1:0] c;
    m = '0;
    for (int x = 0; x < NN * NN; x++) begin
      c = CW'(base + x * step);
      m[x*CW +: CW] = c;
    end
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input string tag, input logic [LAW-1:0] layer,
                         input logic [MW-1:0] exp_w, input logic exp_err);
    bus.rd_layer       = layer;
    bus.rd_layer_valid = 1'b1;
    #1;
    chk({tag, "_rdy"}, MW'(bus.rd_layer_ready), MW'(1'b1));
    tick();
    bus.rd_layer_valid = 1'b0;
    chk({tag, "_wvalid"}, MW'(bus.w_valid), MW'(1'b1));
    chk({tag, "_err"}, MW'(bus.error), MW'(exp_err));
    chk({tag, "_w"}, bus.w, exp_w);
    bus.w_ready = 1'b1;
    tick();
    bus.w_ready = 1'b0;
    chk({tag, "_wvalid_drop"}, MW'(bus.w_valid), MW'(1'b0));
    chk({tag, "_err_clr"}, MW'(bus.error), MW'(1'b0));
  endtask

  task automatic do_write(input string tag, input logic [LAW-1:0] layer,
                          input logic [MW-1:0] data, input logic exp_err);
    bus.wr_layer       = layer;
    bus.wr_layer_valid = 1'b1;
    #1;
    chk({tag, "_rdy"}, MW'(bus.wr_layer_ready), MW'(1'b1));
    tick();
    bus.wr_layer_valid = 1'b0;
    chk({tag, "_dready"}, MW'(bus.wr_data_ready), MW'(1'b1));
    chk({tag, "_err"}, MW'(bus.error), MW'(exp_err));
    bus.wr_data       = data;
    bus.wr_data_valid = 1'b1;
    tick();
    bus.wr_data_valid = 1'b0;
    chk({tag, "_dready_drop"}, MW'(bus.wr_data_ready), MW'(1'b0));
    chk({tag, "_err_clr"}, MW'(bus.error), MW'(1'b0));
    if (int'(layer) < LN) exp_mem[layer] = data;
  endtask

  task automatic read_all(input string tag);
    do_read({tag, "_l0"}, 2'd0, exp_mem[0], 1'b0);
    do_read({tag, "_l1"}, 2'd1, exp_mem[1], 1'b0);
    do_read({tag, "_l2"}, 2'd2, exp_mem[2], 1'b0);
  endtask

  initial begin
    zero_mat = '0;
    pat_a    = pat(1, 1);
    pat_b    = pat(32'h8000, 32'h0101);
    pat_max  = pat(32'h7FFF, 0);
    pat_c    = pat(32'h1234, 3);
    for (int l = 0; l < LN; l++) exp_mem[l] = '0;

    rst                = 1'b1;
    bus.rd_layer       = '0;
    bus.rd_layer_valid = 1'b0;
    bus.w_ready        = 1'b0;
    bus.wr_layer       = '0;
    bus.wr_layer_valid = 1'b0;
    bus.wr_data        = '0;
    bus.wr_data_valid  = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    chk("rst_wvalid", MW'(bus.w_valid), MW'(1'b0));
    chk("rst_err", MW'(bus.error), MW'(1'b0));
    chk("rst_w", bus.w, zero_mat);
    chk("rst_wr_rdy", MW'(bus.wr_layer_ready), MW'(1'b1));
    chk("rst_rd_rdy", MW'(bus.rd_layer_ready), MW'(1'b1));
    chk("rst_wd_rdy", MW'(bus.wr_data_ready), MW'(1'b0));

    do_read("post_rst_rd1", 2'd1, zero_mat, 1'b0);

    do_write("wr_l2", 2'd2, pat_a, 1'b0);
    read_all("raw_a");

    // write and read offered together: write goes first
    bus.rd_layer       = 2'd1;
    bus.rd_layer_valid = 1'b1;
    bus.wr_layer       = 2'd1;
    bus.wr_layer_valid = 1'b1;
    #1;
    chk("prio_rd_rdy", MW'(bus.rd_layer_ready), MW'(1'b0));
    chk("prio_wr_rdy", MW'(bus.wr_layer_ready), MW'(1'b1));
    tick();
    bus.wr_layer_valid = 1'b0;
    chk("prio_wwait", MW'(bus.wr_data_ready), MW'(1'b1));
    chk("prio_no_rd", MW'(bus.w_valid), MW'(1'b0));
    chk("prio_rd_blocked", MW'(bus.rd_layer_ready), MW'(1'b0));
    bus.wr_data       = pat_b;
    bus.wr_data_valid = 1'b1;
    tick();
    bus.wr_data_valid = 1'b0;
    exp_mem[1]        = pat_b;
    chk("prio_rd_rdy_after", MW'(bus.rd_layer_ready), MW'(1'b1));
    tick();
    bus.rd_layer_valid = 1'b0;
    chk("prio_rd_wvalid", MW'(bus.w_valid), MW'(1'b1));
    chk("prio_rd_w", bus.w, pat_b);
    bus.w_ready = 1'b1;
    tick();
    bus.w_ready = 1'b0;
    chk("prio_done", MW'(bus.w_valid), MW'(1'b0));

    // backpressure: stray requests and write data must be ignored in RD_HOLD
    bus.rd_layer       = 2'd2;
    bus.rd_layer_valid = 1'b1;
    tick();
    bus.rd_layer       = 2'd0;
    bus.wr_layer       = 2'd2;
    bus.wr_layer_valid = 1'b1;
    bus.wr_data        = pat_max;
    bus.wr_data_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_wvalid", MW'(bus.w_valid), MW'(1'b1));
      chk("bp_w", bus.w, pat_a);
      chk("bp_rd_rdy", MW'(bus.rd_layer_ready), MW'(1'b0));
      chk("bp_wr_rdy", MW'(bus.wr_layer_ready), MW'(1'b0));
      chk("bp_wd_rdy", MW'(bus.wr_data_ready), MW'(1'b0));
      tick();
    end
    bus.rd_layer_valid = 1'b0;
    bus.wr_layer_valid = 1'b0;
    bus.wr_data_valid  = 1'b0;
    chk("bp_still_w", bus.w, pat_a);
    bus.w_ready = 1'b1;
    tick();
    bus.w_ready = 1'b0;
    chk("bp_done", MW'(bus.w_valid), MW'(1'b0));
    read_all("bp_after");

    do_read("oor_rd", 2'd3, zero_mat, 1'b1);
    do_write("oor_wr", 2'd3, pat_max, 1'b1);
    read_all("oor_after");

    // reset while holding read data
    bus.rd_layer       = 2'd1;
    bus.rd_layer_valid = 1'b1;
    tick();
    bus.rd_layer_valid = 1'b0;
    chk("rst_hold_w", bus.w, pat_b);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int l = 0; l < LN; l++) exp_mem[l] = '0;
    chk("rst_hold_wvalid", MW'(bus.w_valid), MW'(1'b0));
    chk("rst_hold_wzero", bus.w, zero_mat);

    // reset while waiting for write data: the write is abandoned
    bus.wr_layer       = 2'd0;
    bus.wr_layer_valid = 1'b1;
    tick();
    bus.wr_layer_valid = 1'b0;
    chk("rst_ww_dready", MW'(bus.wr_data_ready), MW'(1'b1));
    bus.wr_data       = pat_c;
    bus.wr_data_valid = 1'b1;
    rst               = 1'b1;
    tick();
    rst               = 1'b0;
    bus.wr_data_valid = 1'b0;
    chk("rst_ww_dready_drop", MW'(bus.wr_data_ready), MW'(1'b0));
    chk("rst_ww_idle", MW'(bus.wr_layer_ready), MW'(1'b1));
    read_all("rst_ww_after");

    do_write("final_wr_l0", 2'd0, pat_c, 1'b0);
    read_all("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/weight_store.md
WEIGHT_STORE -- requirements
Module: weight_store

Interface
REQ-001 Parameter NEURON_NUM, default 5, neurons per layer; the matrix holds NEURON_NUM*NEURON_NUM cells.
REQ-002 Parameter WEIGHT_CELL_WIDTH, default 16, width of one signed weight cell.
REQ-003 Parameter LAYER_NUM, default 3, number of stored weight matrices.
REQ-004 Parameter LAYER_ADDR_WIDTH, default 2, width of layer indices; must satisfy 2**LAYER_ADDR_WIDTH >= LAYER_NUM.
REQ-005 Port clk, input, 1 bit, single clock; all logic is on the rising edge.
REQ-006 Port rst, input, 1 bit, synchronous active-high reset.
REQ-007 Port rd_layer, input, LAYER_ADDR_WIDTH bits, index of the layer to read; with rd_layer_valid (in, 1) and rd_layer_ready (out, 1).
REQ-008 Port w, output, NEURON_NUM*NEURON_NUM*WEIGHT_CELL_WIDTH bits, registered weight matrix (cell x at [x*WEIGHT_CELL_WIDTH +: WEIGHT_CELL_WIDTH]); with w_valid (out, 1) and w_ready (in, 1); w feeds the weight updater w input.
REQ-009 Port wr_layer, input, LAYER_ADDR_WIDTH bits, target layer of the next write; with wr_layer_valid (in, 1) and wr_layer_ready (out, 1).
REQ-010 Port wr_data, input, NEURON_NUM*NEURON_NUM*WEIGHT_CELL_WIDTH bits, updated matrix from the weight updater result; with wr_data_valid (in, 1) and wr_data_ready (out, 1).
REQ-011 Port error, output, 1 bit, one-cycle pulse on an out-of-range layer index.

Function
REQ-012 Storage: LAYER_NUM register matrices mem[0..LAYER_NUM-1], each of NEURON_NUM*NEURON_NUM cells.
REQ-013 A transfer occurs on a channel only when its valid and ready are both high at a rising edge.
REQ-014 FSM states: IDLE, RD_HOLD, WR_WAIT.
REQ-015 IDLE: wr_layer_ready=1; rd_layer_ready = NOT wr_layer_valid (combinational); write requests take priority over read requests.
REQ-016 IDLE + wr_layer transfer: latch wr_layer; go to WR_WAIT.
REQ-017 IDLE + rd_layer transfer: load w <= mem[rd_layer] (all zeros if rd_layer >= LAYER_NUM); go to RD_HOLD; read latency is 1 cycle (accept at edge N, w_valid=1 after edge N).
REQ-018 RD_HOLD: w_valid=1; w stays stable; all other readies are 0; on a w transfer, w_valid drops at the same edge and the state goes to IDLE.
REQ-019 WR_WAIT: wr_data_ready=1; all other readies are 0; on a wr_data transfer, mem[latched layer] <= wr_data (discarded if layer >= LAYER_NUM); go to IDLE.
REQ-020 Read-after-write: a read of layer L accepted after a write to L completes returns the new wr_data, bit-exact.
REQ-021 Data passes through unchanged: no arithmetic, saturation, or sign manipulation on cells.
REQ-022 error=1 for exactly the cycle after an accepted rd_layer or wr_layer with index >= LAYER_NUM; otherwise 0.
REQ-023 wr_data_valid outside WR_WAIT is ignored; w_ready outside RD_HOLD is ignored.

Reset
REQ-024 While rst=1 at an edge: state <= IDLE, w_valid <= 0, w <= 0, error <= 0, every mem cell <= 0, latched layer <= 0.
REQ-025 Reset mid-operation (RD_HOLD or WR_WAIT) abandons the transfer; a pending write does not modify mem.
REQ-026 On the first edge after rst deasserts, the block accepts requests as in IDLE.

Verification
REQ-027 Post-reset read: rd_layer=1 -> w_valid after 1 cycle, all 25 cells 0, error=0.
REQ-028 Write then read: wr_layer=2, wr_data cell x = x+1 (16'h0001..16'h0019), then rd_layer=2 -> w matches cell by cell; layers 0 and 1 still read 0.
REQ-029 Priority: rd_layer_valid and wr_layer_valid both high in IDLE -> write accepted, rd_layer_ready=0; the read completes after the write and returns new data.
REQ-030 Backpressure: hold w_ready=0 for 5 cycles in RD_HOLD -> w and w_valid stable, no new requests accepted; the transfer completes when w_ready=1.
REQ-031 Out of range: rd_layer=3 with LAYER_NUM=3 -> error pulse for 1 cycle, w=0; wr_layer=3 followed by wr_data=all 16'h7FFF -> error pulse, no mem change.
REQ-032 Reset in WR_WAIT after wr_layer=0 -> mem[0] stays 0; wr_data_ready=0 after the reset edge.
